// File: rtl/rtc_timekeeper_if.sv
// Control/status bundle between the time-of-day counter and its host:
// time-set handshake, alarm setup and the displayed time with its strobes.
interface rtc_timekeeper_if;
   logic       en;
   logic       mode_12h;
   logic       set_valid;
   logic [5:0] set_hrs;
   logic [5:0] set_min;
   logic [5:0] set_sec;
   logic       set_ack;
   logic       set_err;
   logic       alarm_en;
   logic [5:0] alarm_hrs;
   logic [5:0] alarm_min;
   logic       alarm_clr;
   logic [5:0] count_sec;
   logic [5:0] count_min;
   logic [5:0] count_hrs;
   logic       pm;
   logic       tick_sec;
   logic       roll_min;
   logic       roll_hrs;
   logic       alarm;

   modport master (
      output en, mode_12h, set_valid, set_hrs, set_min, set_sec,
             alarm_en, alarm_hrs, alarm_min, alarm_clr,
      input  set_ack, set_err, count_sec, count_min, count_hrs, pm,
             tick_sec, roll_min, roll_hrs, alarm
   );

   modport slave (
      input  en, mode_12h, set_valid, set_hrs, set_min, set_sec,
             alarm_en, alarm_hrs, alarm_min, alarm_clr,
      output set_ack, set_err, count_sec, count_min, count_hrs, pm,
             tick_sec, roll_min, roll_hrs, alarm
   );
endinterface

// File: rtl/rtc_timekeeper.sv
// Time-of-day counter: prescaled one-second tick feeding cascaded sec/min/hrs
// registers, with validated time load, 12/24h display decode and latched alarm.
module rtc_timekeeper #(
   parameter int unsigned TICK_DIV = 100,
   parameter int unsigned HRS_MAX  = 23
) (
   input  logic               clk,
   input  logic               reset,
   rtc_timekeeper_if.slave    bus
);
   localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [5:0]   HRS_TOP  = 6'(HRS_MAX);
   localparam logic [5:0]   LAST_MS  = 6'd59;

   logic [PW-1:0] presc_q, presc_d;
   logic [5:0]    sec_q, min_q, hrs_q;
   logic [5:0]    sec_d, min_d, hrs_d;
   logic          tick_c, set_ok_c, sec_wrap_c, min_wrap_c, match_c;
   logic          tick_q, roll_min_q, roll_hrs_q, ack_q, err_q, alarm_q;
   logic [5:0]    hrs12_c;

   // Next-time computation; any set request pre-empts a same-cycle tick,
   // and a rejected request leaves every register (prescaler included) alone.
   always_comb begin
      tick_c     = bus.en && (presc_q == PRE_LAST) && !bus.set_valid;
      set_ok_c   = (bus.set_sec <= LAST_MS) && (bus.set_min <= LAST_MS) &&
                   (bus.set_hrs <= HRS_TOP);
      sec_wrap_c = (sec_q == LAST_MS);
      min_wrap_c = sec_wrap_c && (min_q == LAST_MS);
      presc_d    = presc_q;
      sec_d      = sec_q;
      min_d      = min_q;
      hrs_d      = hrs_q;
      if (bus.set_valid) begin
         if (set_ok_c) begin
            presc_d = '0;
            sec_d   = bus.set_sec;
            min_d   = bus.set_min;
            hrs_d   = bus.set_hrs;
         end
      end else if (bus.en) begin
         if (presc_q == PRE_LAST) begin
            presc_d = '0;
            sec_d   = sec_wrap_c ? 6'd0 : sec_q + 6'd1;
            if (sec_wrap_c) min_d = (min_q == LAST_MS) ? 6'd0 : min_q + 6'd1;
            if (min_wrap_c) hrs_d = (hrs_q == HRS_TOP) ? 6'd0 : hrs_q + 6'd1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
      match_c = tick_c && bus.alarm_en && (sec_d == 6'd0) &&
                (min_d == bus.alarm_min) && (hrs_d == bus.alarm_hrs);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q    <= '0;
         sec_q      <= '0;
         min_q      <= '0;
         hrs_q      <= '0;
         tick_q     <= 1'b0;
         roll_min_q <= 1'b0;
         roll_hrs_q <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         alarm_q    <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         sec_q      <= sec_d;
         min_q      <= min_d;
         hrs_q      <= hrs_d;
         tick_q     <= tick_c;
         roll_min_q <= tick_c && sec_wrap_c;
         roll_hrs_q <= tick_c && min_wrap_c;
         ack_q      <= bus.set_valid && set_ok_c;
         err_q      <= bus.set_valid && !set_ok_c;
         alarm_q    <= match_c || (alarm_q && !bus.alarm_clr);
      end
   end

   // 12h decode: 0 shows as 12, 13..23 fold down by 12.
   always_comb begin
      if (hrs_q == 6'd0)       hrs12_c = 6'd12;
      else if (hrs_q > 6'd12)  hrs12_c = hrs_q - 6'd12;
      else                     hrs12_c = hrs_q;
   end

   assign bus.count_sec = sec_q;
   assign bus.count_min = min_q;
   assign bus.count_hrs = bus.mode_12h ? hrs12_c : hrs_q;
   assign bus.pm        = (hrs_q >= 6'd12);
   assign bus.tick_sec  = tick_q;
   assign bus.roll_min  = roll_min_q;
   assign bus.roll_hrs  = roll_hrs_q;
   assign bus.set_ack   = ack_q;
   assign bus.set_err   = err_q;
   assign bus.alarm     = alarm_q;
endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a seconds-of-day model.
module tb_rtc_timekeeper;
   localparam int unsigned TD  = 4;
   localparam int unsigned HM  = 23;
   localparam int          DAY = (HM + 1) * 3600;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rtc_timekeeper_if bus ();
   rtc_timekeeper #(.TICK_DIV(TD), .HRS_MAX(HM)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      vectors++;
      if (act !== 32'(exp)) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int disp(input int h, input logic m12);
      if (!m12)   return h;
      if (h == 0) return 12;
      if (h > 12) return h - 12;
      return h;
   endfunction

   // Reference: time held as seconds since midnight, prescaler as a plain count.
   int m_t, m_p;
   bit m_tick, m_rmin, m_rhrs, m_ack, m_err, m_alarm, m_hit;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_t = 0; m_p = 0; m_tick = 0; m_rmin = 0; m_rhrs = 0;
         m_ack = 0; m_err = 0; m_alarm = 0;
      end else begin
         m_tick = 0; m_rmin = 0; m_rhrs = 0; m_ack = 0; m_err = 0; m_hit = 0;
         if (bus.set_valid) begin
            if (bus.set_sec <= 59 && bus.set_min <= 59 && bus.set_hrs <= HM) begin
               m_t   = int'(bus.set_hrs) * 3600 + int'(bus.set_min) * 60 + int'(bus.set_sec);
               m_p   = 0;
               m_ack = 1;
            end else begin
               m_err = 1;
            end
         end else if (bus.en) begin
            if (m_p == TD - 1) begin
               m_p    = 0;
               m_t    = (m_t + 1) % DAY;
               m_tick = 1;
               m_rmin = (m_t % 60 == 0);
               m_rhrs = (m_t % 3600 == 0);
               m_hit  = bus.alarm_en && bus.alarm_min <= 59 && bus.alarm_hrs <= HM &&
                        (m_t == int'(bus.alarm_hrs) * 3600 + int'(bus.alarm_min) * 60);
            end else begin
               m_p++;
            end
         end
         m_alarm = m_hit || (m_alarm && !bus.alarm_clr);
      end
   end

   bit chk_on = 1'b1;
   always @(negedge clk) begin
      int h;
      if (chk_on) begin
         h = m_t / 3600;
         chk("count_sec", bus.count_sec, m_t % 60);
         chk("count_min", bus.count_min, (m_t / 60) % 60);
         chk("count_hrs", bus.count_hrs, disp(h, bus.mode_12h));
         chk("pm",        bus.pm,        int'(h >= 12));
         chk("tick_sec",  bus.tick_sec,  int'(m_tick));
         chk("roll_min",  bus.roll_min,  int'(m_rmin));
         chk("roll_hrs",  bus.roll_hrs,  int'(m_rhrs));
         chk("set_ack",   bus.set_ack,   int'(m_ack));
         chk("set_err",   bus.set_err,   int'(m_err));
         chk("alarm",     bus.alarm,     int'(m_alarm));
      end
   end

   // Advance n active edges, returning 1 time unit after the last one.
   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_set(input int h, input int m, input int s);
      bus.set_hrs = 6'(h); bus.set_min = 6'(m); bus.set_sec = 6'(s);
      bus.set_valid = 1'b1;
      cyc(1);
      bus.set_valid = 1'b0;
   endtask

   task automatic wait_tick(input int limit, output int n);
      n = 0;
      while (bus.tick_sec !== 1'b1 && n < limit) begin cyc(1); n++; end
   endtask

   task automatic wait_sec0(input int limit, output int n);
      n = 0;
      while (bus.count_sec !== 6'd0 && n < limit) begin cyc(1); n++; end
   endtask

   initial begin
      int n, rolls, ticks;
      bus.en = 0; bus.mode_12h = 0; bus.set_valid = 0;
      bus.set_hrs = 0; bus.set_min = 0; bus.set_sec = 0;
      bus.alarm_en = 0; bus.alarm_hrs = 0; bus.alarm_min = 0; bus.alarm_clr = 0;
      reset = 1'b0;
      #1 reset = 1'b1;
      bus.mode_12h = 1'b1;
      cyc(2);
      chk("rst_hrs12", bus.count_hrs, 12);
      chk("rst_sec",   bus.count_sec, 0);
      chk("rst_pm",    bus.pm,        0);

      // Free-run one minute from reset.
      reset = 1'b0; bus.mode_12h = 1'b0; bus.en = 1'b1;
      rolls = 0; ticks = 0;
      for (int i = 0; i < 240; i++) begin
         cyc(1);
         rolls += int'(bus.roll_min);
         ticks += int'(bus.tick_sec);
      end
      chk("run_ticks", 32'(ticks), 60);
      chk("run_rolls", 32'(rolls), 1);
      chk("run_min",   bus.count_min, 1);
      chk("run_sec",   bus.count_sec, 0);

      // Full-day wrap.
      do_set(23, 59, 59);
      chk("wrap_ack", bus.set_ack, 1);
      wait_tick(10, n);
      chk("wrap_latency", 32'(n), 4);
      chk("wrap_hrs", bus.count_hrs, 0);
      chk("wrap_min", bus.count_min, 0);
      chk("wrap_sec", bus.count_sec, 0);
      chk("wrap_rmin", bus.roll_min, 1);
      chk("wrap_rhrs", bus.roll_hrs, 1);
      bus.mode_12h = 1'b1; #1;
      chk("wrap_hrs12", bus.count_hrs, 12);
      chk("wrap_pm", bus.pm, 0);

      // 12h decode and rejected load.
      do_set(13, 5, 7);
      chk("pm_hrs12", bus.count_hrs, 1);
      chk("pm_pm", bus.pm, 1);
      do_set(13, 5, 60);
      chk("bad_err", bus.set_err, 1);
      chk("bad_ack", bus.set_ack, 0);
      chk("bad_sec", bus.count_sec, 7);
      chk("bad_min", bus.count_min, 5);
      bus.mode_12h = 1'b0;

      // Alarm rise, clear/match collision, clear, and direct set onto alarm time.
      bus.alarm_hrs = 6'd7; bus.alarm_min = 6'd30; bus.alarm_en = 1'b1;
      do_set(7, 29, 58);
      chk("al_idle", bus.alarm, 0);
      wait_sec0(20, n);
      chk("al_latency", 32'(n), 8);
      chk("al_min", bus.count_min, 30);
      chk("al_rise", bus.alarm, 1);
      do_set(7, 29, 59);
      chk("al_keep_on_set", bus.alarm, 1);
      bus.alarm_clr = 1'b1;
      cyc(1);
      chk("al_cleared", bus.alarm, 0);
      wait_sec0(20, n);
      chk("al_clr_vs_match", bus.alarm, 1);
      bus.alarm_clr = 1'b0;
      cyc(2);
      chk("al_held", bus.alarm, 1);
      bus.alarm_clr = 1'b1; cyc(1); bus.alarm_clr = 1'b0;
      chk("al_clr", bus.alarm, 0);
      do_set(7, 30, 0);
      chk("al_direct_set", bus.alarm, 0);
      cyc(6);
      chk("al_after_tick", bus.alarm, 0);
      bus.alarm_en = 1'b0;

      // Set landing on the tick edge, then a freeze with the prescaler mid-count.
      do_set(3, 0, 0);
      cyc(3);
      do_set(1, 2, 3);
      chk("coinc_tick", bus.tick_sec, 0);
      chk("coinc_sec", bus.count_sec, 3);
      chk("coinc_hrs", bus.count_hrs, 1);
      cyc(2);
      bus.en = 1'b0;
      cyc(10);
      chk("freeze_sec", bus.count_sec, 3);
      bus.en = 1'b1;
      wait_tick(10, n);
      chk("freeze_resume", 32'(n), 2);
      chk("freeze_sec4", bus.count_sec, 4);

      // Asynchronous reset in the middle of a count.
      do_set(12, 34, 56);
      cyc(2);
      #2 reset = 1'b1;
      #1;
      chk("arst_sec", bus.count_sec, 0);
      chk("arst_min", bus.count_min, 0);
      chk("arst_hrs", bus.count_hrs, 0);
      chk("arst_pm",  bus.pm, 0);
      cyc(1);
      reset = 1'b0;
      wait_tick(10, n);
      chk("arst_restart", 32'(n), 4);
      chk("arst_sec1", bus.count_sec, 1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc(1);
         reset         = ($urandom % 800 == 0);
         bus.en        = ($urandom % 10 != 0);
         if ($urandom % 32 == 0) bus.mode_12h = ~bus.mode_12h;
         bus.set_valid = ($urandom % 25 == 0);
         bus.set_hrs   = 6'($urandom_range(0, 25));
         bus.set_min   = 6'($urandom_range(56, 61));
         bus.set_sec   = 6'($urandom_range(54, 61));
         bus.alarm_clr = ($urandom % 60 == 0);
         if ($urandom % 8 == 0) bus.alarm_en = ($urandom % 4 != 0);
         if ($urandom % 40 == 0) begin
            bus.alarm_hrs = 6'(m_t / 3600);
            bus.alarm_min = 6'(((m_t / 60) + 1) % 60);
            if ($urandom % 6 == 0) bus.alarm_min = 6'($urandom_range(60, 63));
         end
      end
      reset = 1'b0; bus.set_valid = 1'b0; bus.alarm_clr = 1'b0;
      cyc(2);
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
